// File: rtl/voice_mixer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | voice_mixer: scans NUM_CHANNELS voices per sample_tick and sums the gated |
// | wave samples into one mixed output. Option macro: MIX_SATURATE_EN.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module voice_mixer #(
  parameter int WIDTH        = 18,
  parameter int NUM_CHANNELS = 16,
  parameter int PIPE_LAT     = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sample_tick,
  input  logic [NUM_CHANNELS-1:0]                 note_active,
  input  logic signed [WIDTH-1:0]                 wave_in,
  output logic [NUM_CHANNELS-1:0]                 chan_sel,
  output logic                                    busy,
  output logic signed [WIDTH-1:0]                 mix_out,
  output logic                                    mix_valid,
  output logic                                    overrun,
  output logic [$clog2(NUM_CHANNELS+1)-1:0]       active_cnt
);

  localparam int c_LOG2N = $clog2(NUM_CHANNELS);
  localparam int c_AW    = WIDTH + c_LOG2N;
  localparam int c_CW    = $clog2(NUM_CHANNELS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [c_LOG2N-1:0]       r_idx;
  logic [1:0]               r_drain_cnt;
  logic [PIPE_LAT-1:0]      r_gate_pipe;
  logic signed [c_AW-1:0]   r_acc;
  logic signed [c_AW-1:0]   w_acc_next;
  logic signed [c_AW-1:0]   w_wave_ext;
  logic [c_CW-1:0]          r_cnt;
  logic [c_CW-1:0]          w_cnt_next;
  logic                     w_gate_in;
  logic                     w_gate_out;
  logic [WIDTH-1:0]         w_mix_result;

  // Gate is captured while the channel is selected, so later note_active edits are ignored.
  assign w_gate_in  = (r_state == SCAN) && note_active[r_idx];
  assign w_gate_out = r_gate_pipe[PIPE_LAT-1];
  assign w_wave_ext = {{c_LOG2N{wave_in[WIDTH-1]}}, wave_in};
  assign w_acc_next = w_gate_out ? (r_acc + w_wave_ext) : r_acc;
  assign w_cnt_next = r_cnt + c_CW'(w_gate_out);
  assign busy       = (r_state != IDLE);

  generate
    if (PIPE_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk) begin
        if (rst) r_gate_pipe <= '0;
        else     r_gate_pipe <= w_gate_in;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
        if (rst) r_gate_pipe <= '0;
        else     r_gate_pipe <= {r_gate_pipe[PIPE_LAT-2:0], w_gate_in};
      end
    end
  endgenerate

`ifdef MIX_SATURATE_EN
  localparam logic signed [c_AW-1:0] c_SAT_MAX = {{(c_LOG2N+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [c_AW-1:0] c_SAT_MIN = {{(c_LOG2N+1){1'b1}}, {(WIDTH-1){1'b0}}};
  always_comb begin
    w_mix_result = w_acc_next[WIDTH-1:0];
    if (w_acc_next > c_SAT_MAX)      w_mix_result = c_SAT_MAX[WIDTH-1:0];
    else if (w_acc_next < c_SAT_MIN) w_mix_result = c_SAT_MIN[WIDTH-1:0];
  end
`else
  // Dividing by the channel count keeps any full-scale mix inside WIDTH bits.
  always_comb begin
    w_mix_result = w_acc_next[c_AW-1:c_LOG2N];
  end
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (sample_tick) w_state_next = SCAN;
      SCAN:    if (r_idx == c_LOG2N'(NUM_CHANNELS - 1)) w_state_next = DRAIN;
      DRAIN:   if (r_drain_cnt == 2'(PIPE_LAT - 1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    chan_sel = '0;
    if (r_state == SCAN) chan_sel[r_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      mix_out     <= '0;
      active_cnt  <= '0;
      mix_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      overrun   <= sample_tick && (r_state != IDLE);
      mix_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sample_tick) begin
            r_idx <= '0;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        SCAN: begin
          r_idx       <= r_idx + c_LOG2N'(1);
          r_drain_cnt <= '0;
          r_acc       <= w_acc_next;
          r_cnt       <= w_cnt_next;
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 2'd1;
          r_acc       <= w_acc_next;
          r_cnt       <= w_cnt_next;
          // The last channel's sample lands on this edge, so publish the bypassed sum.
          if (w_state_next == DONE) begin
            mix_out    <= w_mix_result;
            active_cnt <= w_cnt_next;
            mix_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_voice_mixer: directed self-checking bench for voice_mixer.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_voice_mixer;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_tick;
  logic [15:0]        note_active;
  logic signed [17:0] wave_in;
  logic [15:0]        chan_sel;
  logic               busy;
  logic signed [17:0] mix_out;
  logic               mix_valid;
  logic               overrun;
  logic [4:0]         active_cnt;

  logic               tick3;
  logic signed [17:0] wave3;
  logic [15:0]        chan_sel3;
  logic               busy3;
  logic signed [17:0] mix_out3;
  logic               mix_valid3;
  logic               overrun3;
  logic [4:0]         active_cnt3;
  int                 d1, d2, d3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  voice_mixer dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .note_active(note_active),
    .wave_in(wave_in), .chan_sel(chan_sel), .busy(busy), .mix_out(mix_out),
    .mix_valid(mix_valid), .overrun(overrun), .active_cnt(active_cnt)
  );

  voice_mixer #(.WIDTH(18), .NUM_CHANNELS(16), .PIPE_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .sample_tick(tick3), .note_active(16'hFFFF),
    .wave_in(wave3), .chan_sel(chan_sel3), .busy(busy3), .mix_out(mix_out3),
    .mix_valid(mix_valid3), .overrun(overrun3), .active_cnt(active_cnt3)
  );

  // Note generator for the PIPE_LAT=3 instance: channel k answers 100*k three cycles later.
  function automatic int sel_idx(input logic [15:0] sel);
    int r = 0;
    for (int i = 0; i < 16; i++) if (sel[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    d1 <= sel_idx(chan_sel3);
    d2 <= d1;
    d3 <= d2;
  end
  assign wave3 = 18'(d3 * 100);

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame at default parameters; act_late replaces note_active from T+2 onward.
  task automatic frame(input logic [15:0] act, input logic [15:0] act_late,
                       input logic signed [17:0] w, input longint exp_mix,
                       input longint exp_cnt);
    int stray = 0;
    note_active = act;
    wave_in     = w;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      if (k == 2) note_active = act_late;
      if (k <= 16) check("chan_sel", longint'(chan_sel), longint'(1) << (k - 1));
      if (k == 17) check("chan_sel_drain", longint'(chan_sel), 0);
      if (k < 18 && mix_valid) stray++;
      if (k == 18) begin
        check("mix_valid", longint'(mix_valid), 1);
        check("busy_done", longint'(busy), 1);
        check("mix_out", longint'(mix_out), exp_mix);
        check("active_cnt", longint'(active_cnt), exp_cnt);
        step();
      end else begin
        step();
      end
    end
    check("early_valid", stray, 0);
    check("busy_idle", longint'(busy), 0);
    check("valid_pulse", longint'(mix_valid), 0);
  endtask

  initial begin
    longint e_small, e_late, e_ramp;
`ifdef MIX_SATURATE_EN
    e_small = 2000;
    e_late  = 1000;
    e_ramp  = 12000;
`else
    e_small = 125;
    e_late  = 62;
    e_ramp  = 750;
`endif
    rst = 1'b1; sample_tick = 1'b0; tick3 = 1'b0; note_active = '0; wave_in = '0;
    repeat (3) step();
    check("rst_busy", longint'(busy), 0);
    check("rst_chan_sel", longint'(chan_sel), 0);
    check("rst_mix_out", longint'(mix_out), 0);
    check("rst_valid", longint'(mix_valid), 0);
    rst = 1'b0;
    step();

    frame(16'h0000, 16'h0000, 18'sd1000, 0, 0);
    frame(16'h0009, 16'h0009, 18'sd1000, e_small, 2);
    frame(16'hFFFF, 16'hFFFF, 18'sd131071, 131071, 16);
    frame(16'hFFFF, 16'hFFFF, -18'sd131072, -131072, 16);
    frame(16'h0001, 16'h0000, 18'sd1000, e_late, 1);

    // Ticks while busy (mid-scan and in DONE) only raise overrun.
    note_active = 16'h0009; wave_in = 18'sd1000;
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      sample_tick = (k == 5 || k == 18);
      check($sformatf("overrun_c%0d", k), longint'(overrun), longint'(k == 6 || k == 19));
      check($sformatf("valid_c%0d", k), longint'(mix_valid), longint'(k == 18));
      if (k == 18) check("ovr_mix_out", longint'(mix_out), e_small);
      if (k >= 19) check("ovr_no_restart", longint'(busy), 0);
      step();
    end
    sample_tick = 1'b0;

    // Reset at T+8 with a coincident tick aborts the frame.
    note_active = 16'hFFFF; wave_in = 18'sd500;
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    rst = 1'b1; sample_tick = 1'b1;
    step();
    rst = 1'b0; sample_tick = 1'b0;
    check("abort_busy", longint'(busy), 0);
    check("abort_chan_sel", longint'(chan_sel), 0);
    check("abort_mix_out", longint'(mix_out), 0);
    check("abort_cnt", longint'(active_cnt), 0);
    begin
      int stray = 0;
      for (int k = 0; k < 14; k++) begin
        if (mix_valid || busy) stray++;
        step();
      end
      check("abort_quiet", stray, 0);
    end
    frame(16'h0009, 16'h0009, 18'sd1000, e_small, 2);

    // PIPE_LAT=3 instance with a per-channel ramp.
    tick3 = 1'b1; step(); tick3 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) check("p3_chan_sel", longint'(chan_sel3), 1);
      if (k == 19) check("p3_no_early_valid", longint'(mix_valid3), 0);
      if (k == 20) begin
        check("p3_valid", longint'(mix_valid3), 1);
        check("p3_mix_out", longint'(mix_out3), e_ramp);
        check("p3_cnt", longint'(active_cnt3), 16);
      end
      step();
    end
    check("p3_idle", longint'(busy3), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
